// File: rtl/gamepad_pkg.sv
// Shared types and button index constants for the serial gamepad poller.
// Indices refer to positions within one pad's snapshot field; the first bit shifted is the MSB.
package gamepad_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StSettle,
    StPulseHi,
    StPulseLo,
    StDone
  } state_e;

  // NES, 8-bit field
  localparam int unsigned BTN_A     = 7;
  localparam int unsigned BTN_B     = 6;
  localparam int unsigned BTN_SEL   = 5;
  localparam int unsigned BTN_START = 4;
  localparam int unsigned BTN_U     = 3;
  localparam int unsigned BTN_D     = 2;
  localparam int unsigned BTN_L     = 1;
  localparam int unsigned BTN_R     = 0;

  // SNES, 16-bit field; the low four bits are unused by the pad
  localparam int unsigned SNES_B     = 15;
  localparam int unsigned SNES_Y     = 14;
  localparam int unsigned SNES_SEL   = 13;
  localparam int unsigned SNES_START = 12;
  localparam int unsigned SNES_U     = 11;
  localparam int unsigned SNES_D     = 10;
  localparam int unsigned SNES_L     = 9;
  localparam int unsigned SNES_R     = 8;
  localparam int unsigned SNES_A     = 7;
  localparam int unsigned SNES_X     = 6;
  localparam int unsigned SNES_TL    = 5;
  localparam int unsigned SNES_TR    = 4;

endpackage

// File: rtl/gamepad_if.sv
// Connector-side and host-side signals of the gamepad poller.
// master = the poller, slave = the pads plus the consuming logic.
interface gamepad_if #(
  parameter int unsigned NUM_PADS    = 2,
  parameter int unsigned NUM_BUTTONS = 8
) ();

  localparam int unsigned Width = NUM_PADS * NUM_BUTTONS;

  logic [NUM_PADS-1:0] data;
  logic                poll_req;
  logic                latch;
  logic                pulse;
  logic                busy;
  logic                axiov;
  logic [Width-1:0]    axiod;
  logic [Width-1:0]    pressed;
  logic [Width-1:0]    released;

  modport master (
    input  data, poll_req,
    output latch, pulse, busy, axiov, axiod, pressed, released
  );

  modport slave (
    output data, poll_req,
    input  latch, pulse, busy, axiov, axiod, pressed, released
  );

endinterface

// File: rtl/gamepad_sync.sv
// Two-flop synchronizer for a vector of asynchronous inputs.
module gamepad_sync #(
  parameter int unsigned Width    = 1,
  parameter bit          ResetVal = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= {Width{ResetVal}};
      sync_q <= {Width{ResetVal}};
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/gamepad_poller.sv
// Polls NUM_PADS serial NES/SNES pads over a shared latch/pulse pair and reports a snapshot
// plus press/release edge vectors once per poll.
module gamepad_poller
  import gamepad_pkg::*;
#(
  parameter int unsigned NUM_PADS     = 2,
  parameter int unsigned NUM_BUTTONS  = 8,
  parameter int unsigned LATCH_CYCLES = 600,
  parameter int unsigned HALF_CYCLES  = 300,
  parameter bit          AUTO_POLL    = 1'b1,
  parameter int unsigned POLL_PERIOD  = 1666666
) (
  input logic       clk,
  input logic       rst,
  gamepad_if.master bus_io
);

  localparam int unsigned W      = NUM_PADS * NUM_BUTTONS;
  localparam int unsigned MaxCnt = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt);
  localparam int unsigned BitW   = $clog2(NUM_BUTTONS);
  localparam int unsigned TmrW   = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [BitW-1:0]     bit_q, bit_d;
  logic [TmrW-1:0]     tmr_q, tmr_d;
  logic                pend_q, pend_d;
  logic [W-1:0]        shift_q, shift_d, shift_in;
  logic [W-1:0]        hist_q, hist_d;
  logic [W-1:0]        axiod_q, axiod_d;
  logic [W-1:0]        pressed_q, pressed_d;
  logic [W-1:0]        released_q, released_d;
  logic                axiov_q, axiov_d;
  logic [NUM_PADS-1:0] data_sync;
  logic                wrap, start, half_last, latch_last;

  // Pad lines idle high (released), so the synchronizer resets to ones.
  gamepad_sync #(
    .Width   (NUM_PADS),
    .ResetVal(1'b1)
  ) u_sync (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (bus_io.data),
    .q_o  (data_sync)
  );

  assign half_last  = (cnt_q == CntW'(HALF_CYCLES - 1));
  assign latch_last = (cnt_q == CntW'(LATCH_CYCLES - 1));

  always_comb begin
    shift_in = shift_q;
    for (int p = 0; p < int'(NUM_PADS); p++) begin
      shift_in[p*NUM_BUTTONS +: NUM_BUTTONS] =
        {shift_q[p*NUM_BUTTONS +: NUM_BUTTONS-1], ~data_sync[p]};
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    pend_d     = pend_q;
    shift_d    = shift_q;
    hist_d     = hist_q;
    axiod_d    = axiod_q;
    axiov_d    = 1'b0;
    pressed_d  = '0;
    released_d = '0;
    tmr_d      = '0;
    wrap       = 1'b0;

    if (AUTO_POLL) begin
      wrap  = (tmr_q == TmrW'(POLL_PERIOD - 1));
      tmr_d = wrap ? '0 : tmr_q + 1'b1;
    end
    start = AUTO_POLL ? (wrap || pend_q) : bus_io.poll_req;
    // A wrap while a poll is running is remembered and served on the first idle cycle.
    if (wrap && (state_q != StIdle)) pend_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLatch;
          cnt_d   = '0;
          bit_d   = '0;
          pend_d  = 1'b0;
        end
      end
      StLatch: begin
        cnt_d = cnt_q + 1'b1;
        if (latch_last) begin
          cnt_d   = '0;
          state_d = StSettle;
        end
      end
      StSettle: begin
        cnt_d = cnt_q + 1'b1;
        if (half_last) begin
          cnt_d   = '0;
          shift_d = shift_in;
          bit_d   = BitW'(1);
          state_d = StPulseHi;
        end
      end
      StPulseHi: begin
        cnt_d = cnt_q + 1'b1;
        if (half_last) begin
          cnt_d   = '0;
          state_d = StPulseLo;
        end
      end
      StPulseLo: begin
        cnt_d = cnt_q + 1'b1;
        if (half_last) begin
          cnt_d   = '0;
          shift_d = shift_in;
          if (bit_q == BitW'(NUM_BUTTONS - 1)) begin
            state_d    = StDone;
            axiov_d    = 1'b1;
            axiod_d    = shift_in;
            pressed_d  = shift_in & ~hist_q;
            released_d = ~shift_in & hist_q;
            hist_d     = shift_in;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = StPulseHi;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      tmr_q      <= '0;
      pend_q     <= 1'b0;
      shift_q    <= '0;
      hist_q     <= '0;
      axiod_q    <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      axiov_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tmr_q      <= tmr_d;
      pend_q     <= pend_d;
      shift_q    <= shift_d;
      hist_q     <= hist_d;
      axiod_q    <= axiod_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      axiov_q    <= axiov_d;
    end
  end

  assign bus_io.latch    = (state_q == StLatch);
  assign bus_io.pulse    = (state_q == StPulseHi);
  assign bus_io.busy     = (state_q != StIdle);
  assign bus_io.axiov    = axiov_q;
  assign bus_io.axiod    = axiod_q;
  assign bus_io.pressed  = pressed_q;
  assign bus_io.released = released_q;

endmodule

// File: tb/tb_gamepad_poller.sv
// Bench for gamepad_poller: behavioural shift-register pads, a scoreboard of expected snapshots,
// and four DUT configurations (manual 8-bit, auto 100, auto 50, manual 16-bit).
module tb_gamepad_poller;
  import gamepad_pkg::*;

  typedef struct {
    logic [15:0] d;
    logic [15:0] p;
    logic [15:0] r;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [15:0] hist_m = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gamepad_if #(.NUM_PADS(2), .NUM_BUTTONS(8))  bus_a ();
  gamepad_if #(.NUM_PADS(2), .NUM_BUTTONS(8))  bus_b ();
  gamepad_if #(.NUM_PADS(2), .NUM_BUTTONS(8))  bus_c ();
  gamepad_if #(.NUM_PADS(2), .NUM_BUTTONS(16)) bus_d ();

  gamepad_poller #(.NUM_PADS(2), .NUM_BUTTONS(8), .LATCH_CYCLES(8), .HALF_CYCLES(4),
                   .AUTO_POLL(1'b0), .POLL_PERIOD(1000))
    u_a (.clk(clk), .rst(rst), .bus_io(bus_a));
  gamepad_poller #(.NUM_PADS(2), .NUM_BUTTONS(8), .LATCH_CYCLES(8), .HALF_CYCLES(4),
                   .AUTO_POLL(1'b1), .POLL_PERIOD(100))
    u_b (.clk(clk), .rst(rst), .bus_io(bus_b));
  gamepad_poller #(.NUM_PADS(2), .NUM_BUTTONS(8), .LATCH_CYCLES(8), .HALF_CYCLES(4),
                   .AUTO_POLL(1'b1), .POLL_PERIOD(50))
    u_c (.clk(clk), .rst(rst), .bus_io(bus_c));
  gamepad_poller #(.NUM_PADS(2), .NUM_BUTTONS(16), .LATCH_CYCLES(8), .HALF_CYCLES(4),
                   .AUTO_POLL(1'b0), .POLL_PERIOD(1000))
    u_d (.clk(clk), .rst(rst), .bus_io(bus_d));

  // Pad model A: latch loads buttons, each pulse rising edge shifts the next one out.
  logic [15:0] btn_a = '0;
  logic [15:0] sr_a = '0;
  logic        pls_a_q = 1'b0;
  int          edges_a = 0, latch_a = 0, nval_a = 0;
  always @(posedge clk) begin
    pls_a_q <= bus_a.pulse;
    if (bus_a.latch) begin
      sr_a    <= btn_a;
      latch_a <= latch_a + 1;
    end else if (bus_a.pulse && !pls_a_q) begin
      sr_a    <= {sr_a[14:8], 1'b0, sr_a[6:0], 1'b0};
      edges_a <= edges_a + 1;
    end
    if (bus_a.axiov) nval_a <= nval_a + 1;
  end
  assign bus_a.data = ~{sr_a[15], sr_a[7]};

  logic [31:0] btn_d = '0;
  logic [31:0] sr_d = '0;
  logic        pls_d_q = 1'b0;
  int          edges_d = 0;
  always @(posedge clk) begin
    pls_d_q <= bus_d.pulse;
    if (bus_d.latch) sr_d <= btn_d;
    else if (bus_d.pulse && !pls_d_q) begin
      sr_d    <= {sr_d[30:16], 1'b0, sr_d[14:0], 1'b0};
      edges_d <= edges_d + 1;
    end
  end
  assign bus_d.data = ~{sr_d[31], sr_d[15]};

  // Auto-poll DUTs: no buttons, poll_req held high to show it is ignored.
  assign bus_b.data     = 2'b11;
  assign bus_c.data     = 2'b11;
  assign bus_b.poll_req = 1'b1;
  assign bus_c.poll_req = 1'b1;
  int unsigned ts_b[$];
  int unsigned ts_c[$];
  always @(posedge clk) begin
    if (bus_b.axiov) ts_b.push_back(cyc);
    if (bus_c.axiov) ts_c.push_back(cyc);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One poll on DUT A; optionally re-request at cycle 20 while busy.
  task automatic poll_a(input logic [15:0] btn, input bit extra_req);
    exp_t e;
    int   lat, e0, l0, v0;
    @(negedge clk);
    btn_a = btn;
    e.d = btn;
    e.p = btn & ~hist_m;
    e.r = ~btn & hist_m;
    hist_m = btn;
    sb.push_back(e);
    e0 = edges_a;
    l0 = latch_a;
    v0 = nval_a;
    bus_a.poll_req = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      bus_a.poll_req = extra_req && (lat == 20);
    end while (!bus_a.axiov && lat < 200);
    check("latency", lat, 69);
    e = sb.pop_front();
    check("axiod", bus_a.axiod, e.d);
    check("pressed", bus_a.pressed, e.p);
    check("released", bus_a.released, e.r);
    check("busy_in_done", bus_a.busy, 1);
    @(negedge clk);
    check("busy_after_done", bus_a.busy, 0);
    check("axiov_after_done", bus_a.axiov, 0);
    check("pressed_after_done", bus_a.pressed, 0);
    check("axiod_hold", bus_a.axiod, e.d);
    check("pulse_edges", edges_a - e0, 7);
    check("latch_cycles", latch_a - l0, 8);
    check("axiov_count", nval_a - v0, 1);
  endtask

  initial begin
    int          lat, v, e0;
    int unsigned nb0, nc0;
    bus_a.poll_req = 1'b0;
    bus_d.poll_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_latch", bus_a.latch, 0);
    check("rst_pulse", bus_a.pulse, 0);
    check("rst_busy", bus_a.busy, 0);
    check("rst_axiov", bus_a.axiov, 0);
    check("rst_axiod", bus_a.axiod, 0);
    check("rst_pressed", bus_a.pressed, 0);
    check("rst_released", bus_a.released, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    poll_a(16'((1 << BTN_A) | (1 << BTN_START)), 1'b0);
    poll_a(16'((1 << (8 + BTN_R)) | (1 << BTN_START)), 1'b0);
    poll_a(16'((1 << (8 + BTN_R)) | (1 << BTN_START)), 1'b1);
    v = nval_a;
    repeat (100) @(negedge clk);
    check("req_while_busy_ignored", nval_a - v, 0);

    // Abort a poll during the third pulse-high phase.
    @(negedge clk);
    btn_a = 16'h8001;
    e0 = edges_a;
    bus_a.poll_req = 1'b1;
    @(negedge clk);
    bus_a.poll_req = 1'b0;
    repeat (29) @(negedge clk);
    check("pulse_hi_bit3", bus_a.pulse, 1);
    check("edges_before_abort", edges_a - e0, 3);
    rst = 1'b1;
    v = nval_a;
    @(negedge clk);
    rst = 1'b0;
    hist_m = '0;
    check("abort_latch", bus_a.latch, 0);
    check("abort_pulse", bus_a.pulse, 0);
    check("abort_busy", bus_a.busy, 0);
    check("abort_axiod", bus_a.axiod, 0);
    repeat (100) @(negedge clk);
    check("abort_no_snapshot", nval_a - v, 0);
    poll_a(16'h8001, 1'b0);

    // Auto polling from a fresh reset.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nb0 = ts_b.size();
    nc0 = ts_c.size();
    for (int i = 0; i < 500 && (ts_b.size() < nb0 + 3 || ts_c.size() < nc0 + 3); i++) begin
      @(negedge clk);
    end
    check("auto100_count", ts_b.size() >= nb0 + 3, 1);
    check("auto50_count", ts_c.size() >= nc0 + 3, 1);
    if (ts_b.size() >= nb0 + 3) begin
      check("auto100_period1", ts_b[nb0+1] - ts_b[nb0], 100);
      check("auto100_period2", ts_b[nb0+2] - ts_b[nb0+1], 100);
    end
    if (ts_c.size() >= nc0 + 3) begin
      check("auto50_back2back1", ts_c[nc0+1] - ts_c[nc0], 70);
      check("auto50_back2back2", ts_c[nc0+2] - ts_c[nc0+1], 70);
    end

    // 16-button pads: all held on pad 1.
    @(negedge clk);
    btn_d = 32'hFFFF_0000;
    e0 = edges_d;
    bus_d.poll_req = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      bus_d.poll_req = 1'b0;
    end while (!bus_d.axiov && lat < 300);
    check("snes_latency", lat, 133);
    check("snes_axiod", bus_d.axiod, 32'hFFFF_0000);
    check("snes_pressed", bus_d.pressed, 32'hFFFF_0000);
    check("snes_pulse_edges", edges_d - e0, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
